// File: rtl/serial_port.sv
// 8051-style serial port, mode 1 (start, 8 data LSB-first, stop), timed from the Timer 1 overflow.
// Produces one-clock TI/RI set pulses for the SFR file; TX and RX run independently.
module serial_port #(
  parameter int unsigned OVS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_tick,
  input  logic       smod,
  input  logic       ren,
  input  logic       ri,
  input  logic       sbuf_we,
  input  logic [7:0] sbuf_wdata,
  output logic [7:0] sbuf_rdata,
  input  logic       rxd,
  output logic       txd,
  output logic       ti_set,
  output logic       ri_set,
  output logic       tx_busy
);

  localparam int unsigned TickW = $clog2(OVS);
  localparam logic [TickW-1:0] TickLast  = TickW'(OVS - 1);
  localparam logic [TickW-1:0] TickVoteA = TickW'(OVS / 2 - 1);
  localparam logic [TickW-1:0] TickVoteB = TickW'(OVS / 2);
  localparam logic [TickW-1:0] TickVoteC = TickW'(OVS / 2 + 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Sample tick: every baud_tick when smod=1, every second one otherwise.
  logic smod_q;
  logic tog_q;
  logic stick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smod_q <= 1'b0;
      tog_q  <= 1'b0;
    end else begin
      smod_q <= smod;
      if (smod != smod_q) begin
        tog_q <= 1'b0;
      end else if (baud_tick && !smod) begin
        tog_q <= ~tog_q;
      end
    end
  end

  assign stick = smod ? baud_tick : (baud_tick & tog_q);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  state_e           tx_state;
  logic [TickW-1:0] tx_tick;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shreg;

  // txd takes each state's level on that state's first stick, so every level lasts OVS sticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= StIdle;
      tx_tick  <= '0;
      tx_bit   <= 3'd0;
      tx_shreg <= 8'h00;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
      ti_set   <= 1'b0;
    end else begin
      ti_set <= 1'b0;
      if (tx_state == StIdle) begin
        if (sbuf_we) begin
          tx_shreg <= sbuf_wdata;
          tx_busy  <= 1'b1;
          tx_bit   <= 3'd0;
          tx_tick  <= '0;
          tx_state <= StStart;
        end
      end else if (stick) begin
        tx_tick <= (tx_tick == TickLast) ? '0 : tx_tick + 1'b1;
        unique case (tx_state)
          StStart: begin
            if (tx_tick == '0) txd <= 1'b0;
            if (tx_tick == TickLast) tx_state <= StData;
          end
          StData: begin
            if (tx_tick == '0) txd <= tx_shreg[0];
            if (tx_tick == TickLast) begin
              tx_shreg <= {1'b0, tx_shreg[7:1]};
              tx_bit   <= tx_bit + 3'd1;
              if (tx_bit == 3'd7) tx_state <= StStop;
            end
          end
          StStop: begin
            if (tx_tick == '0) begin
              txd    <= 1'b1;
              ti_set <= 1'b1;
            end
            if (tx_tick == TickLast) begin
              tx_state <= StIdle;
              tx_busy  <= 1'b0;
            end
          end
          StIdle: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic rx_s1;
  logic rx_s2;
  logic rx_prev;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;

  state_e           rx_state;
  logic [TickW-1:0] rx_tick;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shreg;
  logic             vote_a;
  logic             vote_b;
  logic             vote;

  // Majority of the two earlier mid-bit samples and the live one on the last sample tick.
  assign vote = (vote_a & vote_b) | (vote_a & rx_s2) | (vote_b & rx_s2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= StIdle;
      rx_tick    <= '0;
      rx_bit     <= 3'd0;
      rx_shreg   <= 8'h00;
      vote_a     <= 1'b1;
      vote_b     <= 1'b1;
      sbuf_rdata <= 8'h00;
      ri_set     <= 1'b0;
    end else begin
      ri_set <= 1'b0;
      if (!ren) begin
        rx_state <= StIdle;
        rx_tick  <= '0;
      end else if (rx_state == StIdle) begin
        if (rx_fall) begin
          rx_tick  <= '0;
          rx_bit   <= 3'd0;
          rx_state <= StStart;
        end
      end else if (stick) begin
        rx_tick <= (rx_tick == TickLast) ? '0 : rx_tick + 1'b1;
        if (rx_tick == TickVoteA) vote_a <= rx_s2;
        if (rx_tick == TickVoteB) vote_b <= rx_s2;
        unique case (rx_state)
          StStart: begin
            if (rx_tick == TickVoteC && vote) begin
              rx_state <= StIdle;
              rx_tick  <= '0;
            end else if (rx_tick == TickLast) begin
              rx_state <= StData;
            end
          end
          StData: begin
            if (rx_tick == TickVoteC) rx_shreg <= {vote, rx_shreg[7:1]};
            if (rx_tick == TickLast) begin
              rx_bit <= rx_bit + 3'd1;
              if (rx_bit == 3'd7) rx_state <= StStop;
            end
          end
          StStop: begin
            // Decide mid-stop so the receiver is re-armed before the next start edge.
            if (rx_tick == TickVoteC) begin
              if (vote && !ri) begin
                sbuf_rdata <= rx_shreg;
                ri_set     <= 1'b1;
              end
              rx_state <= StIdle;
              rx_tick  <= '0;
            end
          end
          StIdle: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_port.sv
// Randomized scoreboard bench for serial_port: stimulus queues expected bytes, monitors decode
// txd frames and ri_set pulses and compare against a frame-level model.
module tb_serial_port;

  localparam int BaudDiv = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       smod = 1'b1;
  logic       ren = 1'b0;
  logic       ri = 1'b0;
  logic       sbuf_we = 1'b0;
  logic [7:0] sbuf_wdata = 8'h00;
  logic [7:0] sbuf_rdata;
  logic       rxd;
  logic       txd;
  logic       ti_set;
  logic       ri_set;
  logic       tx_busy;

  logic       rxd_drv = 1'b1;
  logic       loop = 1'b0;
  logic       mon_en = 1'b1;

  int total = 0;
  int bad = 0;
  int frames_seen = 0;
  int tx_accepted = 0;
  int ti_total = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  assign rxd = loop ? txd : rxd_drv;

  serial_port #(.OVS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .smod      (smod),
    .ren       (ren),
    .ri        (ri),
    .sbuf_we   (sbuf_we),
    .sbuf_wdata(sbuf_wdata),
    .sbuf_rdata(sbuf_rdata),
    .rxd       (rxd),
    .txd       (txd),
    .ti_set    (ti_set),
    .ri_set    (ri_set),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin : baud_gen
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      c++;
      baud_tick = (c % BaudDiv == 0);
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  function automatic int bit_clks();
    return 16 * BaudDiv * (smod ? 1 : 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Counts every ti_set pulse so stray pulses outside frames are caught at the end.
  initial begin : ti_counter
    forever begin
      @(negedge clk);
      if (rst_n && ti_set) ti_total++;
    end
  end

  initial begin : rx_mon
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (rst_n && ri_set) begin
        if (rx_exp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_spurious_ri_set: got pulse with sbuf_rdata=%02h, want none", sbuf_rdata);
        end else begin
          want = rx_exp.pop_front();
          chk("rx_data", {24'h0, sbuf_rdata}, {24'h0, want});
        end
      end
    end
  end

  // Decodes one txd frame from its falling start edge: level at 1/4 and 3/4 of every bit,
  // edges only on bit boundaries, one ti_set at the stop-bit start, tx_busy falling late in stop.
  initial begin : tx_mon
    logic       prev;
    int         bp;
    int         sp;
    int         ti_n;
    logic       ti_bad;
    logic       edge_bad;
    logic       busy_pre;
    logic       busy_post;
    logic       last;
    logic       aborted;
    logic [9:0] lo;
    logic [9:0] hi;
    logic [9:0] want;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en && prev && !txd) begin
        bp = bit_clks();
        sp = bp / 16;
        ti_n = 0;
        ti_bad = 1'b0;
        edge_bad = 1'b0;
        busy_pre = 1'b0;
        busy_post = 1'b1;
        last = 1'b0;
        aborted = 1'b0;
        lo = '0;
        hi = '0;
        for (int p = 0; p < 10 * bp; p++) begin
          if (p > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (txd !== last) begin
            if (p % bp != 0) edge_bad = 1'b1;
            last = txd;
          end
          if (p % bp == bp / 4) lo[p/bp] = txd;
          if (p % bp == 3 * bp / 4) hi[p/bp] = txd;
          if (ti_set) begin
            ti_n++;
            if (p != 9 * bp) ti_bad = 1'b1;
          end
          if (p == 10 * bp - sp - 1) busy_pre = tx_busy;
          if (p == 10 * bp - sp) busy_post = tx_busy;
        end
        prev = aborted ? 1'b1 : last;
        if (!aborted) begin
          if (tx_exp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_spurious_frame: got frame %03h, want none", lo);
          end else begin
            want = {1'b1, tx_exp.pop_front(), 1'b0};
            chk("tx_frame_early", {22'h0, lo}, {22'h0, want});
            chk("tx_frame_late", {22'h0, hi}, {22'h0, want});
            chk("tx_edge_on_bit_boundary", {31'h0, edge_bad}, 32'h0);
            chk("ti_set_count", ti_n, 1);
            chk("ti_set_at_stop_start", {31'h0, ti_bad}, 32'h0);
            chk("tx_busy_in_stop", {31'h0, busy_pre}, 32'h1);
            chk("tx_busy_after_stop", {31'h0, busy_post}, 32'h0);
          end
          frames_seen++;
        end
      end else begin
        prev = txd;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Call at a negedge; the strobe is sampled by the following posedge.
  task automatic wr_now(input logic [7:0] b, input bit accept);
    sbuf_we = 1'b1;
    sbuf_wdata = b;
    if (accept) begin
      tx_exp.push_back(b);
      tx_accepted++;
      if (loop && ren && !ri) rx_exp.push_back(b);
    end
    @(negedge clk);
    sbuf_we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] b, input bit accept);
    @(negedge clk);
    wr_now(b, accept);
  endtask

  task automatic wait_tx();
    int lim;
    lim = 20 * bit_clks();
    for (int i = 0; i < lim && frames_seen < tx_accepted; i++) @(negedge clk);
    chk("tx_frames_done", frames_seen, tx_accepted);
  endtask

  task automatic wait_fall();
    logic p;
    int   lim;
    p = txd;
    lim = 4 * bit_clks();
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (p && !txd) return;
      p = txd;
    end
    total++;
    bad++;
    $display("FAIL tx_start_timeout: got no start edge, want one within %0d clk", lim);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input bit expect_rx);
    logic [9:0] frame;
    int         bp;
    frame = {stop, b, 1'b0};
    bp = bit_clks();
    if (expect_rx) rx_exp.push_back(b);
    for (int k = 0; k < 10; k++) begin
      rxd_drv = frame[k];
      repeat (bp) @(negedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  initial begin : stim
    logic [7:0] b;
    logic [7:0] b2;
    logic [7:0] rb;
    logic [7:0] keep;

    // Reset with baud ticks running
    rst_n = 1'b0;
    idle(3);
    chk("reset_txd", {31'h0, txd}, 32'h1);
    chk("reset_tx_busy", {31'h0, tx_busy}, 32'h0);
    chk("reset_sbuf_rdata", {24'h0, sbuf_rdata}, 32'h0);
    chk("reset_ti_set", {31'h0, ti_set}, 32'h0);
    chk("reset_ri_set", {31'h0, ri_set}, 32'h0);
    rst_n = 1'b1;
    idle(4);

    // Basic transmit at smod=1
    smod = 1'b1;
    wr(8'hA5, 1'b1);
    wait_tx();
    for (int i = 0; i < 2; i++) begin
      wr(8'($urandom), 1'b1);
      wait_tx();
    end

    // Write while busy is dropped
    wr(8'h3C, 1'b1);
    idle(3 * bit_clks());
    wr(8'hFF, 1'b0);
    wait_tx();

    // Write on the clock where tx_busy falls is dropped; one clock later it is taken
    b = 8'($urandom);
    b2 = 8'($urandom);
    wr(b, 1'b1);
    wait_fall();
    idle(159 * (bit_clks() / 16) - 1);
    wr_now(~b2, 1'b0);
    wr_now(b2, 1'b1);
    wait_tx();
    idle(8);

    // Reset mid-frame returns txd high without waiting for a clock
    mon_en = 1'b0;
    wr(8'h00, 1'b0);
    wait_fall();
    idle(bit_clks() + 5);
    rst_n = 1'b0;
    #1;
    chk("async_reset_txd", {31'h0, txd}, 32'h1);
    chk("async_reset_tx_busy", {31'h0, tx_busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    mon_en = 1'b1;

    // Loopback at smod=0, then random bytes at random rates
    smod = 1'b0;
    idle(4);
    loop = 1'b1;
    ren = 1'b1;
    ri = 1'b0;
    wr(8'h5A, 1'b1);
    wait_tx();
    idle(10);
    chk("loopback_rdata", {24'h0, sbuf_rdata}, 32'h5A);
    for (int i = 0; i < 4; i++) begin
      smod = 1'($urandom);
      idle(4);
      b = 8'($urandom);
      wr(b, 1'b1);
      wait_tx();
      idle(10);
      chk("loopback_rand_rdata", {24'h0, sbuf_rdata}, {24'h0, b});
    end
    loop = 1'b0;
    smod = 1'b0;
    idle(4);

    // Short glitch is a false start; the next real frame still lands
    rxd_drv = 1'b0;
    idle(3);
    rxd_drv = 1'b1;
    idle(bit_clks());
    rb = 8'($urandom);
    send_rx(rb, 1'b1, 1'b1);
    idle(8);
    chk("after_glitch_rdata", {24'h0, sbuf_rdata}, {24'h0, rb});

    // Framing error: stop bit low
    keep = rb;
    send_rx(8'h81, 1'b0, 1'b0);
    idle(bit_clks() / 2);
    chk("framing_keeps_rdata", {24'h0, sbuf_rdata}, {24'h0, keep});

    // Overrun: ri already set
    ri = 1'b1;
    send_rx(8'h11, 1'b1, 1'b0);
    ri = 1'b0;
    idle(8);
    chk("overrun_keeps_rdata", {24'h0, sbuf_rdata}, {24'h0, keep});

    // ren dropped mid-data aborts the frame
    fork
      send_rx(8'h33, 1'b1, 1'b0);
      begin
        idle(4 * bit_clks() + bit_clks() / 2);
        ren = 1'b0;
      end
    join
    idle(bit_clks());
    chk("ren_abort_keeps_rdata", {24'h0, sbuf_rdata}, {24'h0, keep});
    ren = 1'b1;
    idle(4);
    send_rx(8'h22, 1'b1, 1'b1);
    idle(8);
    chk("reenable_rdata", {24'h0, sbuf_rdata}, 32'h22);

    // Transmit and receive at the same time
    for (int i = 0; i < 3; i++) begin
      smod = 1'($urandom);
      idle(4);
      b = 8'($urandom);
      rb = 8'($urandom);
      fork
        wr(b, 1'b1);
        send_rx(rb, 1'b1, 1'b1);
      join
      wait_tx();
      idle(8);
      chk("concurrent_rdata", {24'h0, sbuf_rdata}, {24'h0, rb});
    end

    idle(bit_clks());
    chk("tx_queue_drained", tx_exp.size(), 0);
    chk("rx_queue_drained", rx_exp.size(), 0);
    chk("ti_set_total", ti_total, tx_accepted);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
